// File: rtl/gf180mcu_ocd_io__pwr_pkg.sv
// Shared types and sizing helpers for the pad-ring power-up sequencer.
package gf180mcu_ocd_io__pwr_pkg;

    typedef enum logic [1:0] {
        PWR_OFF      = 2'd0,
        PWR_DEBOUNCE = 2'd1,
        PWR_ISO_REL  = 2'd2,
        PWR_RUN      = 2'd3
    } pwr_state_e;

    localparam int BOR_CNT_W = 8;

    // One spare bit above the largest terminal count so the shared counter never wraps.
    function automatic int cnt_width(input int deb_cycles, input int hold_cycles);
        int max_cycles;
        max_cycles = (deb_cycles > hold_cycles) ? deb_cycles : hold_cycles;
        return $clog2(max_cycles) + 1;
    endfunction

endpackage

// File: rtl/gf180mcu_ocd_io__sync2.sv
// Two-flop synchronizer for an asynchronous supply-good flag.
module gf180mcu_ocd_io__sync2 (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/gf180mcu_ocd_io__pwr_seq.sv
// Power-up sequencer: debounces VDD/DVDD good, then releases isolation, I/O enable and PORB in order.
// state    | meaning
// OFF      | rails not good, pads isolated, core in reset
// DEBOUNCE | both rails good, counting DEB_CYCLES before release
// ISO_REL  | isolation released, I/O enabled, PORB held for HOLD_CYCLES
// RUN      | fully powered, PORB released
module gf180mcu_ocd_io__pwr_seq
    import gf180mcu_ocd_io__pwr_pkg::*;
#(
    parameter int DEB_CYCLES  = 16,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 VDD_OK,
    input  logic                 DVDD_OK,
    output logic                 ISO,
    output logic                 IO_EN,
    output logic                 PORB,
    output logic [1:0]           PWR_STATE,
    output logic                 BOR_PULSE,
    output logic [BOR_CNT_W-1:0] BOR_CNT
);

    localparam int CNT_W = cnt_width(DEB_CYCLES, HOLD_CYCLES);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic vdd_sync;
    logic dvdd_sync;
    logic good;

    pwr_state_e           state_q,     state_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic                 iso_q,       iso_d;
    logic                 io_en_q,     io_en_d;
    logic                 porb_q,      porb_d;
    logic                 bor_pulse_q, bor_pulse_d;
    logic [BOR_CNT_W-1:0] bor_cnt_q,   bor_cnt_d;

    gf180mcu_ocd_io__sync2 u_sync_vdd (
        .CLK (CLK),
        .RST (RST),
        .d   (VDD_OK),
        .q   (vdd_sync)
    );

    gf180mcu_ocd_io__sync2 u_sync_dvdd (
        .CLK (CLK),
        .RST (RST),
        .d   (DVDD_OK),
        .q   (dvdd_sync)
    );

    assign good = vdd_sync & dvdd_sync;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bor_pulse_d = 1'b0;
        bor_cnt_d   = bor_cnt_q;

        // Supply loss takes priority over any terminal count in the same cycle.
        if (state_q != PWR_OFF && !good) begin
            state_d = PWR_OFF;
            cnt_d   = '0;
            if (state_q == PWR_ISO_REL || state_q == PWR_RUN) begin
                bor_pulse_d = 1'b1;
                if (bor_cnt_q != '1) begin
                    bor_cnt_d = bor_cnt_q + BOR_CNT_W'(1);
                end
            end
        end else begin
            case (state_q)
                PWR_OFF: begin
                    if (good) begin
                        state_d = PWR_DEBOUNCE;
                        cnt_d   = '0;
                    end
                end
                PWR_DEBOUNCE: begin
                    if (cnt_q == DEB_LAST) begin
                        state_d = PWR_ISO_REL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PWR_ISO_REL: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = PWR_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        // Outputs follow the next state so they change on the same edge as the state register.
        iso_d   = (state_d == PWR_OFF) || (state_d == PWR_DEBOUNCE);
        io_en_d = !iso_d;
        porb_d  = (state_d == PWR_RUN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= PWR_OFF;
            cnt_q       <= '0;
            iso_q       <= 1'b1;
            io_en_q     <= 1'b0;
            porb_q      <= 1'b0;
            bor_pulse_q <= 1'b0;
            bor_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            iso_q       <= iso_d;
            io_en_q     <= io_en_d;
            porb_q      <= porb_d;
            bor_pulse_q <= bor_pulse_d;
            bor_cnt_q   <= bor_cnt_d;
        end
    end

    assign ISO       = iso_q;
    assign IO_EN     = io_en_q;
    assign PORB      = porb_q;
    assign PWR_STATE = state_q;
    assign BOR_PULSE = bor_pulse_q;
    assign BOR_CNT   = bor_cnt_q;

endmodule
